// File: rtl/odo_sbox_prog.sv
// rtl/odo_sbox_prog.sv - programmable double-buffered S-box with permutation-checked shadow load
//
// Purpose: LANES parallel WIDTH-bit substitutions per cycle from the active
// bank, while a shadow bank is reloaded and checked to be a permutation
// before it may be promoted.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_in_valid, i_in_data    lookup request, lane i = i_in_data[i*WIDTH +: WIDTH]
//   o_out_valid, o_out_data  lookup result, one cycle later, lane-aligned
//   i_ld_start               begin a new shadow load (clears load tracking)
//   i_ld_valid/addr/data     shadow write strobe, entry index, entry value
//   i_swap                   promote the shadow bank (only honoured in READY)
//   o_bank_sel               index of the active bank
//   o_ld_busy/ready/fail     load FSM is in LOAD / READY / FAIL
//   o_ld_err                 one-cycle pulse on a rejected write or swap
module odo_sbox_prog #(
  parameter int WIDTH = 6,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_in_valid,
  input  logic [LANES*WIDTH-1:0] i_in_data,
  output logic                   o_out_valid,
  output logic [LANES*WIDTH-1:0] o_out_data,
  input  logic                   i_ld_start,
  input  logic                   i_ld_valid,
  input  logic [WIDTH-1:0]       i_ld_addr,
  input  logic [WIDTH-1:0]       i_ld_data,
  input  logic                   i_swap,
  output logic                   o_bank_sel,
  output logic                   o_ld_busy,
  output logic                   o_ld_ready,
  output logic                   o_ld_fail,
  output logic                   o_ld_err
);

  localparam int DEPTH = 1 << WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [WIDTH-1:0]         r_bank0 [DEPTH];
  logic [WIDTH-1:0]         r_bank1 [DEPTH];
  logic [DEPTH-1:0]         r_written;
  logic [DEPTH-1:0]         r_seen;
  logic [WIDTH:0]           r_count;
  logic                     r_dup;
  logic                     r_bank_sel;
  logic                     r_out_valid;
  logic [LANES*WIDTH-1:0]   r_out_data;
  logic                     r_busy;
  logic                     r_ready;
  logic                     r_fail;
  logic                     r_err;

  logic                     w_in_load;
  logic                     w_wr_acc;
  logic                     w_wr_rej;
  logic                     w_swap_acc;
  logic                     w_swap_rej;
  logic                     w_dup_next;
  logic                     w_last;
  logic [LANES*WIDTH-1:0]   w_lookup;

  // ld_start overrides everything in its cycle: a coincident write or swap is
  // dropped silently rather than flagged.
  assign w_in_load  = (r_state == S_LOAD);
  assign w_wr_acc   = i_ld_valid & ~i_ld_start & w_in_load & ~r_written[i_ld_addr];
  assign w_wr_rej   = i_ld_valid & ~i_ld_start & ~(w_in_load & ~r_written[i_ld_addr]);
  assign w_swap_acc = i_swap & ~i_ld_start & (r_state == S_READY);
  assign w_swap_rej = i_swap & ~i_ld_start & (r_state != S_READY);
  // The duplicate check includes the value being written this cycle so the
  // final write's verdict is ready in time for the transition.
  assign w_dup_next = r_dup | r_seen[i_ld_data];
  assign w_last     = w_wr_acc & (r_count == (WIDTH+1)'(DEPTH - 1));

  always_comb begin
    w_state_next = r_state;
    if (i_ld_start) begin
      w_state_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (w_last) w_state_next = w_dup_next ? S_FAIL : S_READY;
        S_READY: if (w_swap_acc) w_state_next = S_IDLE;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Lookups only ever address the active bank.
  always_comb begin
    w_lookup = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lookup[i*WIDTH +: WIDTH] = r_bank_sel ? r_bank1[i_in_data[i*WIDTH +: WIDTH]]
                                              : r_bank0[i_in_data[i*WIDTH +: WIDTH]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_bank0[k] <= WIDTH'(k);
        r_bank1[k] <= WIDTH'(k);
      end
    end else if (w_wr_acc) begin
      // Shadow bank is the one not selected.
      if (r_bank_sel) r_bank0[i_ld_addr] <= i_ld_data;
      else            r_bank1[i_ld_addr] <= i_ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= i_in_valid;
      r_out_data  <= w_lookup;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_written  <= '0;
      r_seen     <= '0;
      r_count    <= '0;
      r_dup      <= 1'b0;
      r_bank_sel <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_fail     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_LOAD);
      r_ready <= (w_state_next == S_READY);
      r_fail  <= (w_state_next == S_FAIL);
      r_err   <= w_wr_rej | w_swap_rej;
      if (i_ld_start) begin
        r_written <= '0;
        r_seen    <= '0;
        r_count   <= '0;
        r_dup     <= 1'b0;
      end else begin
        if (w_wr_acc) begin
          r_written[i_ld_addr] <= 1'b1;
          r_seen[i_ld_data]    <= 1'b1;
          r_count              <= r_count + (WIDTH+1)'(1);
          r_dup                <= w_dup_next;
        end
        if (w_swap_acc) r_bank_sel <= ~r_bank_sel;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_bank_sel  = r_bank_sel;
  assign o_ld_busy   = r_busy;
  assign o_ld_ready  = r_ready;
  assign o_ld_fail   = r_fail;
  assign o_ld_err    = r_err;

endmodule
